e203_nts_ctx_stack: RTL and testbench
=====================================

Name: e203_nts_ctx_stack

Overview:
- Parametrised nested-trap context stack. Saves and restores one trap frame (caller GPRs plus mcause/mepc/mtval/mstatus) to/from a single-port NTS RAM.
- Frame size and stack depth are generic. The frame is moved as a sequence of BEAT_W-wide beats, so the RAM port is decoupled from the frame width.
- Adds explicit overflow/underflow errors, tail-chain bypass (simultaneous save and restore with no RAM traffic) and a synchronous flush.
- Sits between the trap controller/regfile and the NTS RAM.

Parameters:
- DEPTH, 12, maximum nesting levels stored.
- NREG, 16, GPRs per frame.
- CSR_N, 4, CSR words per frame (order MSB to LSB: mcause, mepc, mtval, mstatus).
- XLEN, 32, register width.
- BEAT_W, 128, RAM data width.
- ADDR_W, 18, RAM word-address width.
- BASE_ADDR, 0, beat address of level-0 frame.
- Derived: FRAME_W=(NREG+CSR_N)*XLEN; BEATS=ceil(FRAME_W/BEAT_W); LVL_W=$clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  sync clear of stack and abort of any operation
- save_req  in  1  single-cycle save request
- save_frame  in  FRAME_W  frame to save, sampled at accept
- restore_req  in  1  single-cycle restore request
- save_done  out  1  pulse: frame committed
- restore_valid  out  1  pulse: restore_frame valid
- restore_frame  out  FRAME_W  restored frame, held until next restore completes
- tc_done  out  1  pulse: tail-chain handled
- busy  out  1  FSM not IDLE
- level  out  LVL_W  frames stored
- full  out  1  level==DEPTH
- nearly_full  out  1  level==DEPTH-1 (controller closes MIE)
- empty  out  1  level==0
- overflow_err  out  1  pulse
- underflow_err  out  1  pulse
- ram_cs  out  1  RAM select
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM beat address
- ram_wem  out  BEAT_W/8  RAM byte write mask
- ram_din  out  BEAT_W  RAM write data
- ram_dout  in  BEAT_W  RAM read data, 1-cycle latency after cs&~we

Behaviour:
- Reset (async): FSM=IDLE; level=0; all pulses, ram_cs, ram_we, ram_wem, ram_din and restore_frame =0; empty=1.
- FSM states: IDLE, WR, RD, RDLAST, DONE.
- Requests are accepted only in IDLE. Requests while busy=1 are ignored silently. The accept cycle is called T.
- Save (level<DEPTH):
  - save_frame is latched at T, zero-padded to BEATS*BEAT_W; beat 0 = LSBs.
  - WR for T+1..T+BEATS: ram_cs=ram_we=1, ram_wem all ones, ram_addr=BASE_ADDR+level*BEATS+beat, ram_din=beat slice.
  - DONE at T+BEATS+1: save_done=1. level increments at that same clock edge, so it is visible in the same cycle as save_done.
- Restore (level>0):
  - level decrements at T+1.
  - RD for T+1..T+BEATS: ram_cs=1, ram_we=0, ram_addr=BASE_ADDR+(new level)*BEATS+beat.
  - Beat k is captured from ram_dout one cycle after its read; RDLAST covers the final capture at T+BEATS+1.
  - restore_valid=1 at T+BEATS+2.
- Tail-chain: save_req and restore_req in the same IDLE cycle with level>0 give tc_done=1 at T+1, level unchanged, no RAM access, FSM stays IDLE.
- Same-cycle save_req and restore_req with level==0: handled as a save only, and underflow_err=1 at T+1.
- Overflow: save_req alone at level==DEPTH gives overflow_err=1 at T+1, no RAM access, no save_done, level unchanged.
- Underflow: restore_req alone at level==0 gives underflow_err=1 at T+1, no RAM access.
- Address arithmetic is done in ADDR_W+LVL_W bits, then truncated to ADDR_W. Configuration guarantees no wrap; an SVA check enforces it.
- flush: at the next edge level=0, FSM=IDLE, ram_cs=0, and no done/valid pulse is generated. It has priority over simultaneous requests. restore_frame is retained.
- Pulses are exactly one cycle wide. full, nearly_full and empty are combinational from level.
- Outside WR/RD, ram_cs=0 and ram_din=0.

Decomposition:
- Package e203_nts_pkg holds:
  - FSM state enum;
  - CSR slot offsets within the frame (MCAUSE_OFS etc.);
  - helper function for the BEATS/ceil computation.
- One sub-module, e203_nts_beat_seq, contains the beat counter, last-beat flag and address generation. The top level holds the FSM, level counter, frame registers and error logic.

Test Plan:
- Defaults (BEATS=5): save frame with bit pattern i→(i%7==0), then restore → 5 writes at addr 0..4, save_done at T+6, level=1; restore reads addr 0..4, restore_valid at T+7, restore_frame equals saved frame.
- 12 back-to-back saves, then a 13th → nearly_full at level 11, full at 12, 13th gives overflow_err pulse with no ram_cs. Then 12 restores return frames in LIFO order, addresses 55..59 first.
- Same-cycle save_req and restore_req at level 3 → tc_done at T+1, level stays 3, ram_cs=0 throughout.
- Restore at level 0 → underflow_err at T+1, restore_frame unchanged, busy never asserted.
- flush at T+2 of a save from level 4 → level 0 next cycle, ram_cs drops, no save_done.
- rst_n low mid-restore at T+3, then BEATS=3 config (NREG=8, BEAT_W=128) → all outputs at reset values; 3-beat save/restore round-trip with correct zero padding.

Source files
------------

// File: rtl/e203_nts_pkg.sv
// Shared types and helpers for the nested-trap context stack.
// The FSM encoding, the CSR word slots and the beat-count arithmetic all live here.
package e203_nts_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDLAST,
    DONE
  } nts_state_e;

  // Word offsets of each CSR inside the CSR field, counted from its least significant word.
  localparam int MSTATUS_OFS = 0;
  localparam int MTVAL_OFS   = 1;
  localparam int MEPC_OFS    = 2;
  localparam int MCAUSE_OFS  = 3;

  function automatic int nts_ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/e203_nts_beat_seq.sv
// Beat sequencer for the context stack: it steps through the beats of one frame and
// forms the RAM beat address from the stack level.
module e203_nts_beat_seq
  import e203_nts_pkg::*;
#(
  parameter int BEATS     = 5,
  parameter int LVL_W     = 4,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0,
  localparam int BEAT_CW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               run_i,
  input  logic [LVL_W-1:0]   level_i,
  output logic [BEAT_CW-1:0] beat_o,
  output logic               last_o,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam int AW2 = ADDR_W + LVL_W;

  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic [AW2-1:0]     addr_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  // The counter falls back to zero after the final beat so the next frame starts cleanly.
  always_comb begin
    beat_d = '0;
    if (run_i && !flush_i && !last_o) beat_d = beat_q + 1'b1;
  end

  assign last_o    = (beat_q == BEAT_CW'(BEATS - 1));
  assign beat_o    = beat_q;
  assign addr_full = AW2'(BASE_ADDR) + AW2'(level_i) * AW2'(BEATS) + AW2'(beat_q);
  assign addr_o    = addr_full[ADDR_W-1:0];

  a_no_addr_wrap : assert property (@(posedge clk) disable iff (!rst_n)
    run_i |-> ((addr_full >> ADDR_W) == '0));

endmodule

// File: rtl/e203_nts_ctx_stack.sv
// Nested-trap context stack: pushes and pops whole trap frames to a single-port RAM
// beat by beat, with tail-chain bypass, overflow/underflow reporting and flush.
module e203_nts_ctx_stack
  import e203_nts_pkg::*;
#(
  parameter int DEPTH      = 12,
  parameter int NREG       = 16,
  parameter int CSR_N      = 4,
  parameter int XLEN       = 32,
  parameter int BEAT_W     = 128,
  parameter int ADDR_W     = 18,
  parameter int BASE_ADDR  = 0,
  localparam int FRAME_W   = (NREG + CSR_N) * XLEN,
  localparam int BEATS     = nts_ceil_div(FRAME_W, BEAT_W),
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  save_req,
  input  logic [FRAME_W-1:0]    save_frame,
  input  logic                  restore_req,
  output logic                  save_done,
  output logic                  restore_valid,
  output logic [FRAME_W-1:0]    restore_frame,
  output logic                  tc_done,
  output logic                  busy,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  nearly_full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [BEAT_W/8-1:0]   ram_wem,
  output logic [BEAT_W-1:0]     ram_din,
  input  logic [BEAT_W-1:0]     ram_dout
);

  localparam int BUF_W   = BEATS * BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  nts_state_e         state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               is_save_q, is_save_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FRAME_W-1:0] rframe_q, rframe_d;
  logic               tc_q, tc_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [BEAT_CW-1:0] beat;
  logic               last_beat;
  logic               seq_run;

  assign seq_run = (state_q == WR) || (state_q == RD);

  e203_nts_beat_seq #(
    .BEATS    (BEATS),
    .LVL_W    (LVL_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_beat_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .run_i  (seq_run),
    .level_i(level_q),
    .beat_o (beat),
    .last_o (last_beat),
    .addr_o (ram_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      is_save_q <= 1'b0;
      buf_q     <= '0;
      rframe_q  <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      is_save_q <= is_save_d;
      buf_q     <= buf_d;
      rframe_q  <= rframe_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // One buffer serves both directions: it holds the outgoing frame during WR and
  // collects returning beats during RD, each beat arriving one cycle after its read.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    is_save_d = is_save_q;
    buf_d     = buf_q;
    rframe_d  = rframe_q;
    tc_d      = 1'b0;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      level_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (save_req && restore_req && (level_q != '0)) begin
            tc_d = 1'b1;
          end else if (save_req) begin
            if (level_q == LVL_W'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              state_d   = WR;
              is_save_d = 1'b1;
              buf_d     = BUF_W'(save_frame);
              udf_d     = restore_req;
            end
          end else if (restore_req) begin
            if (level_q == '0) begin
              udf_d = 1'b1;
            end else begin
              state_d   = RD;
              is_save_d = 1'b0;
              level_d   = level_q - 1'b1;
            end
          end
        end
        WR: begin
          if (last_beat) begin
            state_d = DONE;
            level_d = level_q + 1'b1;
          end
        end
        RD: begin
          if (beat != '0) buf_d[(int'(beat) - 1) * BEAT_W +: BEAT_W] = ram_dout;
          if (last_beat) state_d = RDLAST;
        end
        RDLAST: begin
          buf_d[(BEATS - 1) * BEAT_W +: BEAT_W] = ram_dout;
          rframe_d = buf_d[FRAME_W-1:0];
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ram_cs        = seq_run;
  assign ram_we        = (state_q == WR);
  assign ram_wem       = (state_q == WR) ? '1 : '0;
  assign ram_din       = (state_q == WR) ? buf_q[int'(beat) * BEAT_W +: BEAT_W] : '0;
  assign save_done     = (state_q == DONE) && is_save_q;
  assign restore_valid = (state_q == DONE) && !is_save_q;
  assign restore_frame = rframe_q;
  assign tc_done       = tc_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
  assign busy          = (state_q != IDLE);
  assign level         = level_q;
  assign full          = (level_q == LVL_W'(DEPTH));
  assign nearly_full   = (level_q == LVL_W'(DEPTH - 1));
  assign empty         = (level_q == '0);

endmodule

// File: tb/tb_e203_nts_ctx_stack.sv
// Directed bench for the context stack: RAM traffic and restored frames are predicted
// into queues as requests are issued and compared as the DUT produces them.
module tb_e203_nts_ctx_stack;

  localparam int FW  = 640;
  localparam int FW3 = 384;
  localparam int BW  = 128;
  localparam int AW  = 18;
  localparam int LW  = 4;
  localparam int NB  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush, save_req, restore_req;
  logic [FW-1:0] save_frame, restore_frame;
  logic          save_done, restore_valid, tc_done, busy, full, nearly_full, empty;
  logic          overflow_err, underflow_err, ram_cs, ram_we;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_addr;
  logic [BW/8-1:0] ram_wem;
  logic [BW-1:0] ram_din, ram_dout;

  logic           save_req3, restore_req3;
  logic [FW3-1:0] save_frame3, restore_frame3;
  logic           save_done3, restore_valid3, tc_done3, busy3, full3, nearly_full3, empty3;
  logic           overflow_err3, underflow_err3, ram_cs3, ram_we3;
  logic [LW-1:0]  level3;
  logic [AW-1:0]  ram_addr3;
  logic [BW/8-1:0] ram_wem3;
  logic [BW-1:0]  ram_din3, ram_dout3;

  e203_nts_ctx_stack dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .save_req(save_req), .save_frame(save_frame),
    .restore_req(restore_req), .save_done(save_done), .restore_valid(restore_valid),
    .restore_frame(restore_frame), .tc_done(tc_done), .busy(busy), .level(level),
    .full(full), .nearly_full(nearly_full), .empty(empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  e203_nts_ctx_stack #(.NREG(8), .BEAT_W(128)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .save_req(save_req3), .save_frame(save_frame3),
    .restore_req(restore_req3), .save_done(save_done3), .restore_valid(restore_valid3),
    .restore_frame(restore_frame3), .tc_done(tc_done3), .busy(busy3), .level(level3),
    .full(full3), .nearly_full(nearly_full3), .empty(empty3), .overflow_err(overflow_err3),
    .underflow_err(underflow_err3), .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wem(ram_wem3), .ram_din(ram_din3), .ram_dout(ram_dout3)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] din;
  } acc_t;

  int vecs = 0;
  int errs = 0;
  acc_t accQ[$];
  acc_t curAcc;
  logic [FW-1:0]  frmQ[$];
  logic [FW3-1:0] frm3Q[$];
  logic [FW-1:0]  stk[$];
  logic [BW-1:0]  mem [0:63];
  logic [BW-1:0]  mem3 [0:7];
  int wr3 = 0;
  int rd3 = 0;

  always @(posedge clk) begin
    if (ram_cs && !ram_we) ram_dout <= mem[ram_addr[5:0]];
    if (ram_cs && ram_we)  mem[ram_addr[5:0]] <= ram_din;
    if (ram_cs3 && !ram_we3) ram_dout3 <= mem3[ram_addr3[2:0]];
    if (ram_cs3 && ram_we3)  mem3[ram_addr3[2:0]] <= ram_din3;
  end

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every RAM access and every restored frame must match the next queued prediction.
  always @(negedge clk) begin
    if (rst_n && ram_cs) begin
      if (accQ.size() == 0) begin
        checkOutput("unexpected_ram_cs", FW'(ram_cs), FW'(0));
      end else begin
        curAcc = accQ.pop_front();
        checkOutput("ram_we", FW'(ram_we), FW'(curAcc.we));
        checkOutput("ram_addr", FW'(ram_addr), FW'(curAcc.addr));
        checkOutput("ram_din", FW'(ram_din), FW'(curAcc.din));
        checkOutput("ram_wem", FW'(ram_wem), curAcc.we ? FW'(16'hFFFF) : FW'(0));
      end
    end
    if (rst_n && restore_valid) begin
      if (frmQ.size() == 0) checkOutput("unexpected_restore_valid", FW'(restore_valid), FW'(0));
      else checkOutput("restore_frame", restore_frame, frmQ.pop_front());
    end
    if (rst_n && ram_cs3) begin
      if (ram_we3) begin
        checkOutput("dut3_wr_addr", FW'(ram_addr3), FW'(wr3));
        wr3++;
      end else begin
        checkOutput("dut3_rd_addr", FW'(ram_addr3), FW'(rd3));
        rd3++;
      end
    end
    if (rst_n && restore_valid3) begin
      if (frm3Q.size() == 0) checkOutput("unexpected_restore_valid3", FW'(restore_valid3), FW'(0));
      else checkOutput("restore_frame3", FW'(restore_frame3), FW'(frm3Q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic rv, input logic fl, input logic [FW-1:0] fr);
    save_req = sv;
    restore_req = rv;
    flush = fl;
    save_frame = fr;
    tick();
    save_req = 1'b0;
    restore_req = 1'b0;
    flush = 1'b0;
  endtask

  task automatic apply3(input logic sv, input logic rv, input logic [FW3-1:0] fr);
    save_req3 = sv;
    restore_req3 = rv;
    save_frame3 = fr;
    tick();
    save_req3 = 1'b0;
    restore_req3 = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return save_done;
      1: return restore_valid;
      5: return save_done3;
      6: return restore_valid3;
      default: return 1'b0;
    endcase
  endfunction

  // Latency is counted with the cycle after acceptance as 1; -1 means the pulse never came.
  task automatic awaitPulse(input int which, input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      if (sig(which)) begin
        lat = k;
        return;
      end
      tick();
    end
  endtask

  function automatic logic [FW-1:0] rndFrame();
    logic [FW-1:0] f;
    for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic expectWrites(input logic [FW-1:0] f, input int lvl, input int n);
    acc_t a;
    for (int b = 0; b < n; b++) begin
      a.we = 1'b1;
      a.addr = AW'(lvl * NB + b);
      a.din = f[b*BW +: BW];
      accQ.push_back(a);
    end
  endtask

  task automatic expectReads(input int lvl, input int n);
    acc_t a;
    for (int b = 0; b < n; b++) begin
      a.we = 1'b0;
      a.addr = AW'(lvl * NB + b);
      a.din = '0;
      accQ.push_back(a);
    end
  endtask

  task automatic doSave(input logic [FW-1:0] f);
    int lat;
    int lvl;
    lvl = stk.size();
    expectWrites(f, lvl, NB);
    stk.push_back(f);
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    checkOutput("save_busy", FW'(busy), FW'(1));
    awaitPulse(0, 12, lat);
    checkOutput("save_latency", FW'(lat), FW'(NB + 1));
    checkOutput("save_level", FW'(level), FW'(lvl + 1));
    checkOutput("save_full", FW'(full), FW'(lvl + 1 == 12));
    checkOutput("save_nearly_full", FW'(nearly_full), FW'(lvl + 1 == 11));
    checkOutput("save_empty", FW'(empty), FW'(0));
    tick();
  endtask

  task automatic doRestore();
    int lat;
    int newl;
    newl = stk.size() - 1;
    expectReads(newl, NB);
    frmQ.push_back(stk.pop_back());
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("restore_level", FW'(level), FW'(newl));
    awaitPulse(1, 12, lat);
    checkOutput("restore_latency", FW'(lat), FW'(NB + 2));
    checkOutput("restore_empty", FW'(empty), FW'(newl == 0));
    tick();
  endtask

  task automatic checkResetState();
    checkOutput("rst_level", FW'(level), FW'(0));
    checkOutput("rst_empty", FW'(empty), FW'(1));
    checkOutput("rst_busy", FW'(busy), FW'(0));
    checkOutput("rst_ram_ctl", FW'({ram_cs, ram_we, ram_wem}), FW'(0));
    checkOutput("rst_ram_din", FW'(ram_din), FW'(0));
    checkOutput("rst_restore_frame", restore_frame, FW'(0));
    checkOutput("rst_pulses", FW'({save_done, restore_valid, tc_done, overflow_err, underflow_err}), FW'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [FW-1:0]  f;
    logic [FW-1:0]  lastF;
    logic [FW3-1:0] g;
    int lat;
    flush = 1'b0; save_req = 1'b0; restore_req = 1'b0; save_frame = '0;
    save_req3 = 1'b0; restore_req3 = 1'b0; save_frame3 = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checkResetState();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < FW; i++) f[i] = (i % 7 == 0);
    doSave(f);
    doRestore();

    for (int k = 0; k < 12; k++) doSave(rndFrame());
    applyStimulus(1'b1, 1'b0, 1'b0, rndFrame());
    checkOutput("ovf_pulse", FW'(overflow_err), FW'(1));
    checkOutput("ovf_level", FW'(level), FW'(12));
    checkOutput("ovf_busy", FW'(busy), FW'(0));
    tick();
    checkOutput("ovf_width", FW'(overflow_err), FW'(0));
    awaitPulse(0, 8, lat);
    checkOutput("ovf_no_save_done", FW'(lat), FW'(-1));

    for (int k = 0; k < 9; k++) doRestore();
    applyStimulus(1'b1, 1'b1, 1'b0, rndFrame());
    checkOutput("tc_pulse", FW'(tc_done), FW'(1));
    checkOutput("tc_level", FW'(level), FW'(3));
    checkOutput("tc_busy", FW'(busy), FW'(0));
    tick();
    checkOutput("tc_width", FW'(tc_done), FW'(0));
    checkOutput("tc_level_after", FW'(level), FW'(3));
    for (int k = 0; k < 3; k++) doRestore();

    lastF = restore_frame;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("udf_pulse", FW'(underflow_err), FW'(1));
    checkOutput("udf_busy", FW'(busy), FW'(0));
    checkOutput("udf_frame_kept", restore_frame, lastF);
    tick();
    checkOutput("udf_width", FW'(underflow_err), FW'(0));
    checkOutput("udf_busy_after", FW'(busy), FW'(0));

    f = rndFrame();
    expectWrites(f, 0, NB);
    stk.push_back(f);
    applyStimulus(1'b1, 1'b1, 1'b0, f);
    checkOutput("both_at_empty_udf", FW'(underflow_err), FW'(1));
    checkOutput("both_at_empty_busy", FW'(busy), FW'(1));
    awaitPulse(0, 12, lat);
    checkOutput("both_at_empty_save", FW'(lat), FW'(NB + 1));
    checkOutput("both_at_empty_level", FW'(level), FW'(1));
    tick();
    for (int k = 0; k < 3; k++) doSave(rndFrame());

    f = rndFrame();
    expectWrites(f, 4, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, f);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("flush_level", FW'(level), FW'(0));
    checkOutput("flush_ram_cs", FW'(ram_cs), FW'(0));
    checkOutput("flush_busy", FW'(busy), FW'(0));
    awaitPulse(0, 8, lat);
    checkOutput("flush_no_save_done", FW'(lat), FW'(-1));
    stk.delete();

    doSave(rndFrame());
    expectReads(0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkResetState();
    stk.delete();
    tick();
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < FW3 / 32; w++) g[w*32 +: 32] = $urandom;
    apply3(1'b1, 1'b0, g);
    awaitPulse(5, 10, lat);
    checkOutput("dut3_save_latency", FW'(lat), FW'(4));
    checkOutput("dut3_level", FW'(level3), FW'(1));
    tick();
    frm3Q.push_back(g);
    apply3(1'b0, 1'b1, '0);
    awaitPulse(6, 10, lat);
    checkOutput("dut3_restore_latency", FW'(lat), FW'(5));
    tick();
    checkOutput("dut3_writes", FW'(wr3), FW'(3));
    checkOutput("dut3_reads", FW'(rd3), FW'(3));

    checkOutput("acc_queue_drained", FW'(accQ.size()), FW'(0));
    checkOutput("frame_queue_drained", FW'(frmQ.size() + frm3Q.size()), FW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
